idu_decode_stage: RTL and testbench

- RV32I decode stage directly downstream of the instruction fetch unit.
- Accepts (pc, inst) pairs over a valid/ready handshake and buffers them in a 2-entry skid buffer, so in_ready is a registered signal.
- Presents the decoded fields of the oldest entry to the execute stage over a second valid/ready handshake.
- A flush input discards all buffered instructions on redirect.

---
 rtl/idu_decode_stage.sv | 158 +++++++++++++++
 tb/tb_idu_decode_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_decode_stage.sv
// rtl/idu_decode_stage.sv - RV32I decode stage behind a 2-entry skid buffer
// Registered in_ready; decode is combinational from the head (main) entry.
module idu_decode_stage #(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] RESET_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [31:0]      out_inst,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic [WIDTH-1:0] out_imm,
  output logic [5:0]       out_type,
  output logic             out_illegal,
  output logic             out_ebreak
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_pc, skid_pc;
  logic [31:0]      main_inst, skid_inst;
  logic             main_ld_in, main_ld_skid, skid_ld;
  logic             in_fire, out_fire;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d    = ONE;
          main_ld_in = 1'b1;
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state_d = FULL;
            skid_ld = 1'b1;
          end else if (in_fire) begin
            main_ld_in = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          state_d      = ONE;
          main_ld_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_pc    <= '0;
      main_inst  <= RESET_INST;
      skid_pc    <= '0;
      skid_inst  <= RESET_INST;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (main_ld_in) begin
        main_pc   <= in_pc;
        main_inst <= in_inst;
      end else if (main_ld_skid) begin
        main_pc   <= skid_pc;
        main_inst <= skid_inst;
      end
      if (skid_ld) begin
        skid_pc   <= in_pc;
        skid_inst <= in_inst;
      end
    end
  end

  // Field extraction and immediate formation, {J,U,B,S,I,R} one-hot type
  logic [31:0] imm32;
  logic [5:0]  typ;
  logic        ill;

  always_comb begin
    imm32 = '0;
    typ   = '0;
    ill   = 1'b0;
    case (main_inst[6:0])
      OP_R: typ = 6'b000001;
      OP_LOAD, OP_IMM, OP_JALR, OP_SYS: begin
        typ   = 6'b000010;
        imm32 = {{20{main_inst[31]}}, main_inst[31:20]};
      end
      OP_STORE: begin
        typ   = 6'b000100;
        imm32 = {{20{main_inst[31]}}, main_inst[31:25], main_inst[11:7]};
      end
      OP_BR: begin
        typ   = 6'b001000;
        imm32 = {{20{main_inst[31]}}, main_inst[7], main_inst[30:25], main_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        typ   = 6'b010000;
        imm32 = {main_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        typ   = 6'b100000;
        imm32 = {{12{main_inst[31]}}, main_inst[19:12], main_inst[20], main_inst[30:21], 1'b0};
      end
      default: ill = 1'b1;
    endcase
  end

  assign out_pc       = main_pc;
  assign out_inst     = main_inst;
  assign out_rs1      = main_inst[19:15];
  assign out_rs2      = main_inst[24:20];
  assign out_rd       = main_inst[11:7];
  assign out_funct3   = main_inst[14:12];
  assign out_funct7b5 = main_inst[30];
  assign out_imm      = {{(WIDTH-31){imm32[31]}}, imm32[30:0]};
  assign out_type     = typ;
  assign out_illegal  = ill;
  assign out_ebreak   = (main_inst == 32'h00100073);

endmodule

// File: tb/tb_idu_decode_stage.sv
// tb/tb_idu_decode_stage.sv - self-checking bench for idu_decode_stage
// Decode vector table replayed through a scoreboard, plus handshake corner sequences.
module tb_idu_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [5:0]  typ;
    logic        ill;
    logic        ebk;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_inst, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_illegal, out_ebreak;
  logic [5:0]  out_type;

  idu_decode_stage #(.WIDTH(32), .RESET_INST(32'h00000013)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_imm(out_imm), .out_type(out_type),
    .out_illegal(out_illegal), .out_ebreak(out_ebreak)
  );

  always #5 clk = ~clk;

  rec_t vec [10];
  rec_t sb [$];
  rec_t cur;
  int   checks = 0;
  int   fails = 0;
  int   ticks = 0;
  int   n_out = 0;

  function automatic rec_t mk(logic [31:0] inst, logic [31:0] imm, logic [5:0] typ,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [2:0] f3, logic f7b5, logic ill, logic ebk);
    rec_t r;
    r.pc = '0; r.inst = inst; r.imm = imm; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.f3 = f3; r.f7b5 = f7b5; r.typ = typ; r.ill = ill; r.ebk = ebk;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // One clock: observe fires at negedge, then return #1 after posedge
  task automatic tick();
    rec_t e, a;
    @(negedge clk);
    if (out_valid && out_ready) begin
      checks++;
      n_out++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got pc=%h inst=%h required no output", out_pc, out_inst);
      end else begin
        e = sb.pop_front();
        a.pc = out_pc; a.inst = out_inst; a.imm = out_imm; a.rd = out_rd;
        a.rs1 = out_rs1; a.rs2 = out_rs2; a.f3 = out_funct3; a.f7b5 = out_funct7b5;
        a.typ = out_type; a.ill = out_illegal; a.ebk = out_ebreak;
        if (a !== e) begin
          fails++;
          $display("FAIL decode: got pc=%h inst=%h imm=%h typ=%b rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%b ill=%b ebk=%b required pc=%h inst=%h imm=%h typ=%b rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%b ill=%b ebk=%b",
                   a.pc, a.inst, a.imm, a.typ, a.rd, a.rs1, a.rs2, a.f3, a.f7b5, a.ill, a.ebk,
                   e.pc, e.inst, e.imm, e.typ, e.rd, e.rs1, e.rs2, e.f3, e.f7b5, e.ill, e.ebk);
        end
      end
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(cur);
    @(posedge clk);
    #1;
    ticks++;
  endtask

  task automatic send(rec_t r, logic [31:0] pc);
    logic acc;
    int   n;
    cur = r;
    cur.pc = pc;
    in_pc = pc;
    in_inst = r.inst;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("send_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int t0, o0;
    vec[0] = mk(32'h00500093, 32'h00000005, 6'b000010, 5'd1,  5'd0,  5'd5,  3'd0, 1'b0, 1'b0, 1'b0);
    vec[1] = mk(32'hFE20AE23, 32'hFFFFFFFC, 6'b000100, 5'd28, 5'd1,  5'd2,  3'd2, 1'b1, 1'b0, 1'b0);
    vec[2] = mk(32'hFF9FF0EF, 32'hFFFFFFF8, 6'b100000, 5'd1,  5'd31, 5'd25, 3'd7, 1'b1, 1'b0, 1'b0);
    vec[3] = mk(32'h0000007F, 32'h00000000, 6'b000000, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 1'b1, 1'b0);
    vec[4] = mk(32'h00100073, 32'h00000001, 6'b000010, 5'd0,  5'd0,  5'd1,  3'd0, 1'b0, 1'b0, 1'b1);
    vec[5] = mk(32'h002081B3, 32'h00000000, 6'b000001, 5'd3,  5'd1,  5'd2,  3'd0, 1'b0, 1'b0, 1'b0);
    vec[6] = mk(32'hFE208EE3, 32'hFFFFFFFC, 6'b001000, 5'd29, 5'd1,  5'd2,  3'd0, 1'b1, 1'b0, 1'b0);
    vec[7] = mk(32'h123452B7, 32'h12345000, 6'b010000, 5'd5,  5'd8,  5'd3,  3'd5, 1'b0, 1'b0, 1'b0);
    vec[8] = mk(32'h00812303, 32'h00000008, 6'b000010, 5'd6,  5'd2,  5'd8,  3'd2, 1'b0, 1'b0, 1'b0);
    vec[9] = mk(32'hFFF00093, 32'hFFFFFFFF, 6'b000010, 5'd1,  5'd0,  5'd31, 3'd0, 1'b1, 1'b0, 1'b0);
    cur = vec[0];

    // Reset shows an idle stage holding a nop
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_type", {26'b0, out_type}, 32'h2);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_rd", {27'b0, out_rd}, 32'd0);

    // Single decode with next-cycle latency
    chk("single_pre_valid", {31'b0, out_valid}, 32'd0);
    send(vec[0], 32'h80000000);
    chk("single_latency_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    drain();

    // Streaming every table vector back to back
    t0 = ticks;
    o0 = n_out;
    for (int i = 0; i < 10; i++) send(vec[i], 32'h00001000 + 32'(4 * i));
    chk("stream_cycles", ticks - t0, 10);
    tick();
    chk("stream_outputs", n_out - o0, 10);
    chk("stream_empty", sb.size(), 0);

    // Backpressure: A, B accepted, C held off, FIFO order on release
    out_ready = 1'b0;
    send(vec[1], 32'h80000000);
    send(vec[2], 32'h80000004);
    chk("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    cur = vec[7];
    cur.pc = 32'h80000008;
    in_pc = 32'h80000008;
    in_inst = vec[7].inst;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_pc", out_pc, 32'h80000000);
      chk("bp_hold_imm", out_imm, 32'hFFFFFFFC);
      chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    send(vec[7], 32'h80000008);
    drain();
    chk("bp_idle", {31'b0, out_valid}, 32'd0);

    // Flush while FULL with an instruction offered
    out_ready = 1'b0;
    send(vec[5], 32'h00003000);
    send(vec[6], 32'h00003004);
    cur = vec[8];
    cur.pc = 32'hDEAD0000;
    in_pc = 32'hDEAD0000;
    in_inst = vec[8].inst;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_full_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_full_ready", {31'b0, in_ready}, 32'd1);

    // Flush in ONE: head consumed in the same cycle, offered entry dropped
    send(vec[4], 32'h00004000);
    o0 = n_out;
    cur = vec[9];
    cur.pc = 32'hDEAD0004;
    in_pc = 32'hDEAD0004;
    in_inst = vec[9].inst;
    in_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_one_consumed", n_out - o0, 1);
    chk("flush_one_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_one_ready", {31'b0, in_ready}, 32'd1);
    send(vec[3], 32'h00005000);
    drain();

    // Reset mid-operation drops buffered work immediately
    out_ready = 1'b0;
    send(vec[1], 32'h00006000);
    send(vec[2], 32'h00006004);
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_inst", out_inst, 32'h00000013);
    sb.delete();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("midrst_after_valid", {31'b0, out_valid}, 32'd0);
    send(vec[9], 32'h00007000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
